// File: rtl/mac_sequencer.sv
// mac_sequencer: issues bias load, multiply-accumulate steps and write-back
// to an external MAC ALU and register file. It computes
//   rf[dst] = rf[bias] + sum(rf[a+i] * rf[b+i]) for i in 0..len-1.
//
// Handshake: start is only sampled while IDLE (busy low). Every other start is
// ignored. done is a one-cycle pulse coinciding with the rf_we write-back.
module mac_sequencer #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [REG_ADDR_WIDTH-1:0] bias_addr,
  input  logic [REG_ADDR_WIDTH-1:0] a_base,
  input  logic [REG_ADDR_WIDTH-1:0] b_base,
  input  logic [REG_ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  output logic                      done,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [REG_DATA_WIDTH-1:0] rf_rdata1,
  input  logic [REG_DATA_WIDTH-1:0] rf_rdata2,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [REG_DATA_WIDTH-1:0] rf_wdata,
  output logic                      alu_funct,
  output logic                      alu_mac_en,
  output logic [REG_DATA_WIDTH-1:0] alu_rs1,
  output logic [REG_DATA_WIDTH-1:0] alu_rs2,
  input  logic [REG_DATA_WIDTH-1:0] alu_rd,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MAC  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [REG_ADDR_WIDTH-1:0] bias_q, a_q, b_q, dst_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      idx;
  logic [REG_ADDR_WIDTH-1:0] idx_addr;
  logic                      last_mac;

  // Address offsets wrap modulo the register count, so only the low bits of
  // the index matter for addressing.
  assign idx_addr  = REG_ADDR_WIDTH'(idx);
  assign last_mac  = (idx == len_q - LEN_WIDTH'(1));
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture: only an accepted start (in IDLE) updates the latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dst_q  <= '0;
      len_q  <= '0;
    end else if (state == IDLE && start) begin
      bias_q <= bias_addr;
      a_q    <= a_base;
      b_q    <= b_base;
      dst_q  <= dst_addr;
      len_q  <= len;
    end
  end

  // Product index: cleared in INIT, advanced once per MAC cycle.
  always_ff @(posedge clk) begin
    if (rst)                idx <= '0;
    else if (state == INIT) idx <= '0;
    else if (state == MAC)  idx <= idx + LEN_WIDTH'(1);
  end

  // Next-state and output decode; every output idles at zero.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rf_raddr1  = '0;
    rf_raddr2  = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    alu_funct  = 1'b0;
    alu_mac_en = 1'b0;
    alu_rs1    = '0;
    alu_rs2    = '0;
    case (state)
      IDLE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
        busy       = 1'b1;
        rf_raddr1  = bias_q;
        alu_funct  = 1'b1;
        alu_mac_en = 1'b1;
        alu_rs1    = rf_rdata1;
        state_next = (len_q != '0) ? MAC : WB;
      end
      MAC: begin
        busy       = 1'b1;
        rf_raddr1  = a_q + idx_addr;
        rf_raddr2  = b_q + idx_addr;
        alu_mac_en = 1'b1;
        alu_rs1    = rf_rdata1;
        alu_rs2    = rf_rdata2;
        if (last_mac) state_next = WB;
      end
      WB: begin
        // Operands held at zero so the ALU result is the accumulated psum.
        busy       = 1'b1;
        done       = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = dst_q;
        rf_wdata   = alu_rd;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural register file and MAC ALU.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  bias_addr, a_base, b_base, dst_addr;
  logic [7:0]  len;
  logic        busy, done;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        alu_funct, alu_mac_en;
  logic [15:0] alu_rs1, alu_rs2, alu_rd;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Register file and ALU environment models
  logic [15:0] rf [16];
  logic [15:0] psum;
  logic signed [31:0] prod;
  logic [3:0]  seen1_q[$];
  logic [3:0]  seen2_q[$];
  logic [3:0]  exp_q[$];

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign prod      = $signed(alu_rs1) * $signed(alu_rs2);
  assign alu_rd    = alu_funct ? alu_rs1 : (prod[15:0] + psum);

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (alu_mac_en) psum <= alu_rd;
  end

  // Clock/reset block
  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .bias_addr(bias_addr), .a_base(a_base), .b_base(b_base), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_funct(alu_funct), .alu_mac_en(alu_mac_en),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rf();
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
  endtask

  // Driver: issue one operation and follow it to completion, checking timing,
  // write-back and the final register value.
  task automatic run_op(input logic [3:0] bias, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] dst, input logic [7:0] n, input logic [15:0] exp_val,
                        input string name);
    int done_cyc;
    int mac_cnt;
    int bad_busy;
    done_cyc = -1;
    mac_cnt  = 0;
    bad_busy = 0;
    seen1_q.delete();
    seen2_q.delete();
    bias_addr = bias; a_base = a; b_base = b; dst_addr = dst; len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(n) + 6; c++) begin
      if (busy !== 1'b1) bad_busy++;
      if (alu_mac_en === 1'b1) mac_cnt++;
      if (alu_mac_en === 1'b1 && alu_funct === 1'b0) begin
        seen1_q.push_back(rf_raddr1);
        seen2_q.push_back(rf_raddr2);
      end
      if (done === 1'b1) begin
        done_cyc = c;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== dst || rf_wdata !== exp_val) begin
          errors++;
          $display("FAIL %s writeback: we=%b waddr=%0d wdata=%h, expected we=1 waddr=%0d wdata=%h",
                   name, rf_we, rf_waddr, rf_wdata, dst, exp_val);
        end
        break;
      end
      if (rf_we !== 1'b0) bad_busy++;
      tick();
    end
    checks++;
    if (done_cyc != int'(n) + 2) begin
      errors++;
      $display("FAIL %s done_latency: got %0d, expected %0d", name, done_cyc, int'(n) + 2);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy_during_op: %0d bad cycles, expected 0", name, bad_busy);
    end
    checks++;
    if (mac_cnt != int'(n) + 1) begin
      errors++;
      $display("FAIL %s mac_en_cycles: got %0d, expected %0d", name, mac_cnt, int'(n) + 1);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b done=%b we=%b, expected 0 0 0", name, busy, done, rf_we);
    end
    checks++;
    if (rf[dst] !== exp_val) begin
      errors++;
      $display("FAIL %s rf_dst: got %h, expected %h", name, rf[dst], exp_val);
    end
  endtask

  task automatic load_test1();
    clear_rf();
    rf[0] = 16'd5;
    rf[1] = 16'd1; rf[2] = 16'd2; rf[3] = 16'd3;
    rf[4] = 16'd4; rf[5] = 16'd5; rf[6] = 16'd6;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    bias_addr = 4'h0; a_base = 4'h0; b_base = 4'h0; dst_addr = 4'h0; len = 8'h0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0 || alu_funct !== 1'b0 ||
        alu_mac_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b we=%b funct=%b mac_en=%b, expected all 0",
               busy, done, rf_we, alu_funct, alu_mac_en);
    end
    checks++;
    if (rf_raddr1 !== 4'h0 || rf_raddr2 !== 4'h0 || rf_waddr !== 4'h0 || alu_rs1 !== 16'h0 ||
        alu_rs2 !== 16'h0 || rf_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: ra1=%h ra2=%h wa=%h rs1=%h rs2=%h wd=%h, expected all 0",
               rf_raddr1, rf_raddr2, rf_waddr, alu_rs1, alu_rs2, rf_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_dot();
    load_test1();
    run_op(4'd0, 4'd1, 4'd4, 4'd7, 8'd3, 16'd37, "basic_dot");
  endtask

  task automatic test_len_zero();
    clear_rf();
    rf[8] = 16'h0042;
    run_op(4'd8, 4'd1, 4'd2, 4'd9, 8'd0, 16'h0042, "len_zero");
  endtask

  task automatic test_signed();
    clear_rf();
    rf[11] = 16'hFFFD; rf[12] = 16'd7;
    run_op(4'd10, 4'd11, 4'd12, 4'd13, 8'd1, 16'hFFEB, "signed");
  endtask

  task automatic test_wrap_arith();
    clear_rf();
    rf[0] = 16'h7FFF; rf[1] = 16'd1; rf[2] = 16'd1;
    run_op(4'd0, 4'd1, 4'd2, 4'd3, 8'd1, 16'h8000, "wrap_add");
    clear_rf();
    rf[1] = 16'h4000; rf[2] = 16'd4; rf[3] = 16'h1234;
    run_op(4'd0, 4'd1, 4'd2, 4'd3, 8'd1, 16'h0000, "wrap_mul");
  endtask

  task automatic test_wrap_addr();
    clear_rf();
    rf[1] = 16'd10; rf[15] = 16'd3; rf[0] = 16'd2; rf[14] = 16'd5;
    // 10 + 3*5 + 2*3 = 31
    run_op(4'd1, 4'd15, 4'd14, 4'd2, 8'd2, 16'd31, "wrap_addr");
    exp_q.delete();
    exp_q.push_back(4'd15); exp_q.push_back(4'd0);
    checks++;
    if (seen1_q.size() != 2 || seen1_q[0] !== exp_q[0] || seen1_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL raddr1_seq: got %p, expected %p", seen1_q, exp_q);
    end
    exp_q.delete();
    exp_q.push_back(4'd14); exp_q.push_back(4'd15);
    checks++;
    if (seen2_q.size() != 2 || seen2_q[0] !== exp_q[0] || seen2_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL raddr2_seq: got %p, expected %p", seen2_q, exp_q);
    end
  endtask

  // dst aliases the bias register, then a second start lands in the IDLE
  // cycle right after WB.
  task automatic test_back_to_back();
    load_test1();
    run_op(4'd0, 4'd1, 4'd4, 4'd0, 8'd3, 16'd37, "alias_dst");
    // 37 + 1*4 = 41
    run_op(4'd0, 4'd1, 4'd4, 4'd5, 8'd1, 16'd41, "back_to_back");
  endtask

  task automatic test_start_while_busy();
    int done_seen;
    int we_seen;
    load_test1();
    bias_addr = 4'd0; a_base = 4'd1; b_base = 4'd4; dst_addr = 4'd7; len = 8'd3;
    start = 1'b1;
    tick();                      // INIT
    start = 1'b0;
    tick();                      // MAC 1: stray start with other operands
    bias_addr = 4'd9; a_base = 4'd9; b_base = 4'd9; dst_addr = 4'd10; len = 8'd1;
    start = 1'b1;
    tick();                      // MAC 2
    start = 1'b0;
    tick();                      // MAC 3
    tick();                      // WB
    checks++;
    if (done !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 16'd37) begin
      errors++;
      $display("FAIL start_busy_wb: done=%b waddr=%0d wdata=%h, expected 1 7 0025",
               done, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rf[10] !== 16'h0) begin
      errors++;
      $display("FAIL start_busy_after: busy=%b rf10=%h, expected 0 0000", busy, rf[10]);
    end

    // Reset asserted during the second MAC cycle.
    load_test1();
    rf[7] = 16'hBEEF;
    bias_addr = 4'd0; a_base = 4'd1; b_base = 4'd4; dst_addr = 4'd7; len = 8'd3;
    start = 1'b1;
    tick();                      // INIT
    start = 1'b0;
    tick();                      // MAC 1
    tick();                      // MAC 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_op: busy=%b we=%b done=%b, expected 0 0 0", busy, rf_we, done);
    end
    done_seen = 0;
    we_seen   = 0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) done_seen++;
      if (rf_we === 1'b1) we_seen++;
      tick();
    end
    checks++;
    if (done_seen != 0 || we_seen != 0 || rf[7] !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_quiet: done=%0d we=%0d rf7=%h, expected 0 0 beef",
               done_seen, we_seen, rf[7]);
    end
    run_op(4'd0, 4'd1, 4'd4, 4'd7, 8'd3, 16'd37, "after_rst");
  endtask

  initial begin
    clear_rf();
    psum = 16'h0;
    test_reset();
    test_basic_dot();
    test_len_zero();
    test_signed();
    test_wrap_arith();
    test_wrap_addr();
    test_back_to_back();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
